char_fetch: RTL and testbench

- Upstream pipeline stage of the text-mode character renderer.
- Consumes the raster counters from the sync generator and issues text-RAM and font-ROM addresses.
- Aligns the returned glyph row byte and attribute with pixel index and blank.
- Drives DATA/ATTR/PIXEL/BLANK of the character pixel output stage, all from registers, at a fixed latency.

---
 rtl/char_video_pkg.sv | 30 +++
 rtl/char_fetch_if.sv | 35 +++
 rtl/char_row_addr.sv | 54 +++++
 rtl/char_fetch.sv | 118 +++++++++++
 tb/tb_char_fetch.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/char_video_pkg.sv
// Shared definitions for the text-mode character video path.
// Field positions, widths and the fetch latency the sync generator also relies on.
package char_video_pkg;

   localparam int CHAR_W        = 8;
   localparam int PIX_IDX_W     = 3;
   localparam int FETCH_LATENCY = 5;

   localparam int ATTR_FG_MSB = 7;
   localparam int ATTR_FG_LSB = 4;
   localparam int ATTR_BG_MSB = 3;
   localparam int ATTR_BG_LSB = 0;

   typedef struct packed {
      logic [ATTR_FG_MSB-ATTR_FG_LSB:0] fg;
      logic [ATTR_BG_MSB-ATTR_BG_LSB:0] bg;
   } attr_t;

   // Forces a byte to zero for samples outside the visible area.
   function automatic logic [CHAR_W-1:0] blank_gate(input logic act, input logic [CHAR_W-1:0] val);
      logic [CHAR_W-1:0] res;
      if (act) begin
         res = val;
      end else begin
         res = {CHAR_W{1'b0}};
      end
      return res;
   endfunction

endpackage

// File: rtl/char_fetch_if.sv
// Raster, memory and pixel-stage signals of the character fetch block.
// The slave side is char_fetch; the master side is its environment.
interface char_fetch_if
   import char_video_pkg::*;
#(
   parameter int H_W      = 10,
   parameter int V_W      = 10,
   parameter int TA_W     = 12,
   parameter int ROW_BITS = 4
);

   logic [H_W-1:0]             H_COUNT;
   logic [V_W-1:0]             V_COUNT;
   logic                       ACTIVE;
   logic [TA_W-1:0]            TEXT_ADDR;
   logic [CHAR_W-1:0]          TEXT_CHAR;
   logic [CHAR_W-1:0]          TEXT_ATTR;
   logic [CHAR_W+ROW_BITS-1:0] FONT_ADDR;
   logic [CHAR_W-1:0]          FONT_DATA;
   logic [CHAR_W-1:0]          DATA;
   logic [CHAR_W-1:0]          ATTR;
   logic [PIX_IDX_W-1:0]       PIXEL;
   logic                       BLANK;

   modport master (
      output H_COUNT, V_COUNT, ACTIVE, TEXT_CHAR, TEXT_ATTR, FONT_DATA,
      input  TEXT_ADDR, FONT_ADDR, DATA, ATTR, PIXEL, BLANK
   );

   modport slave (
      input  H_COUNT, V_COUNT, ACTIVE, TEXT_CHAR, TEXT_ATTR, FONT_DATA,
      output TEXT_ADDR, FONT_ADDR, DATA, ATTR, PIXEL, BLANK
   );

endinterface

// File: rtl/char_row_addr.sv
// Tracks the text RAM address of column 0 of the current character row.
// Updated once per line, on the first horizontal-blank pixel.
module char_row_addr
   import char_video_pkg::*;
#(
   parameter int COLS     = 80,
   parameter int ROW_BITS = 4,
   parameter int V_ACTIVE = 480,
   parameter int H_W      = 10,
   parameter int V_W      = 10,
   parameter int TA_W     = 12
) (
   input  logic            PIXCLK,
   input  logic            RESET_N,
   input  logic [H_W-1:0]  i_h_count,
   input  logic [V_W-1:0]  i_v_count,
   output logic [TA_W-1:0] o_row_base
);

   localparam logic [H_W-1:0]  HBLANK_START = H_W'(COLS * 8);
   localparam logic [V_W-1:0]  V_LAST       = V_W'(V_ACTIVE - 1);
   localparam logic [TA_W-1:0] ROW_STRIDE   = TA_W'(COLS);

   logic [TA_W-1:0] r_row_base;
   logic [TA_W-1:0] w_row_base_nxt;

   // Next row base: frame restart wins over row advance.
   always_comb begin
      w_row_base_nxt = r_row_base;
      if (i_h_count == HBLANK_START) begin
         if (i_v_count >= V_LAST) begin
            w_row_base_nxt = {TA_W{1'b0}};
         end else if (&i_v_count[ROW_BITS-1:0]) begin
            w_row_base_nxt = r_row_base + ROW_STRIDE;
         end else begin
            w_row_base_nxt = r_row_base;
         end
      end else begin
         w_row_base_nxt = r_row_base;
      end
   end

   // Row base register.
   always_ff @(posedge PIXCLK) begin
      if (!RESET_N) begin
         r_row_base <= {TA_W{1'b0}};
      end else begin
         r_row_base <= w_row_base_nxt;
      end
   end

   assign o_row_base = r_row_base;

endmodule

// File: rtl/char_fetch.sv
// Character fetch pipeline: raster counters in, glyph row byte, attribute,
// pixel index and blank out, all registered, FETCH_LATENCY clocks later.
module char_fetch
   import char_video_pkg::*;
#(
   parameter int COLS     = 80,
   parameter int ROW_BITS = 4,
   parameter int V_ACTIVE = 480,
   parameter int H_W      = 10,
   parameter int V_W      = 10,
   parameter int TA_W     = 12
) (
   input  logic        PIXCLK,
   input  logic        RESET_N,
   char_fetch_if.slave bus
);

   localparam int FA_W = CHAR_W + ROW_BITS;

   generate
      if (COLS * (V_ACTIVE >> ROW_BITS) > (1 << TA_W)) begin : g_bad_ta_w
         $error("char_fetch: TA_W too narrow for COLS x character rows");
      end
      if (FETCH_LATENCY != 5) begin : g_bad_latency
         $error("char_fetch: pipeline depth is fixed at 5 clocks");
      end
   endgenerate

   logic [TA_W-1:0] w_row_base;

   char_row_addr #(
      .COLS     (COLS),
      .ROW_BITS (ROW_BITS),
      .V_ACTIVE (V_ACTIVE),
      .H_W      (H_W),
      .V_W      (V_W),
      .TA_W     (TA_W)
   ) u_row_addr (
      .PIXCLK     (PIXCLK),
      .RESET_N    (RESET_N),
      .i_h_count  (bus.H_COUNT),
      .i_v_count  (bus.V_COUNT),
      .o_row_base (w_row_base)
   );

   logic [TA_W-1:0]      r_text_addr;
   logic [FA_W-1:0]      r_font_addr;
   logic [CHAR_W-1:0]    r_data;
   logic [CHAR_W-1:0]    r_attr;
   logic [PIX_IDX_W-1:0] r_pixel;
   logic                 r_blank;

   logic [ROW_BITS-1:0]  r_row1, r_row2;
   logic [PIX_IDX_W-1:0] r_pix1, r_pix2, r_pix3, r_pix4;
   logic                 r_act1, r_act2, r_act3, r_act4;
   logic                 r_vld1, r_vld2;
   attr_t                r_attr3, r_attr4;

   // Address issue, memory alignment and side-band delay lines.
   always_ff @(posedge PIXCLK) begin
      if (!RESET_N) begin
         r_text_addr <= {TA_W{1'b0}};
         r_font_addr <= {FA_W{1'b0}};
         r_data      <= {CHAR_W{1'b0}};
         r_attr      <= {CHAR_W{1'b0}};
         r_pixel     <= {PIX_IDX_W{1'b0}};
         r_blank     <= 1'b1;
         r_row1      <= {ROW_BITS{1'b0}};
         r_row2      <= {ROW_BITS{1'b0}};
         r_pix1      <= {PIX_IDX_W{1'b0}};
         r_pix2      <= {PIX_IDX_W{1'b0}};
         r_pix3      <= {PIX_IDX_W{1'b0}};
         r_pix4      <= {PIX_IDX_W{1'b0}};
         r_act1      <= 1'b0;
         r_act2      <= 1'b0;
         r_act3      <= 1'b0;
         r_act4      <= 1'b0;
         r_vld1      <= 1'b0;
         r_vld2      <= 1'b0;
         r_attr3     <= attr_t'({CHAR_W{1'b0}});
         r_attr4     <= attr_t'({CHAR_W{1'b0}});
      end else begin
         r_text_addr <= w_row_base + TA_W'(bus.H_COUNT[H_W-1:PIX_IDX_W]);
         r_row1      <= bus.V_COUNT[ROW_BITS-1:0];
         r_pix1      <= bus.H_COUNT[PIX_IDX_W-1:0];
         r_act1      <= bus.ACTIVE;
         r_vld1      <= 1'b1;

         r_row2      <= r_row1;
         r_pix2      <= r_pix1;
         r_act2      <= r_act1;
         r_vld2      <= r_vld1;

         // RAM word for r_text_addr is on TEXT_CHAR/TEXT_ATTR now.
         r_font_addr <= r_vld2 ? {bus.TEXT_CHAR, r_row2} : {FA_W{1'b0}};
         r_attr3     <= attr_t'(bus.TEXT_ATTR);
         r_pix3      <= r_pix2;
         r_act3      <= r_act2 & r_vld2;

         r_attr4     <= r_attr3;
         r_pix4      <= r_pix3;
         r_act4      <= r_act3;

         r_data      <= blank_gate(r_act4, bus.FONT_DATA);
         r_attr      <= blank_gate(r_act4, r_attr4);
         r_pixel     <= r_pix4;
         r_blank     <= ~r_act4;
      end
   end

   assign bus.TEXT_ADDR = r_text_addr;
   assign bus.FONT_ADDR = r_font_addr;
   assign bus.DATA      = r_data;
   assign bus.ATTR      = r_attr;
   assign bus.PIXEL     = r_pixel;
   assign bus.BLANK     = r_blank;

endmodule

// File: tb/tb_char_fetch.sv
// Self-checking bench for char_fetch: behavioural text RAM / font ROM,
// row-base reference model and a scoreboard queue aligned to the fetch latency.
module tb_char_fetch;
   import char_video_pkg::*;

   localparam int H_W      = 10;
   localparam int V_W      = 10;
   localparam int TA_W     = 12;
   localparam int ROW_BITS = 4;
   localparam int COLS     = 80;
   localparam int V_ACTIVE = 480;

   logic PIXCLK  = 1'b0;
   logic RESET_N = 1'b0;

   always #5 PIXCLK = ~PIXCLK;

   char_fetch_if #(.H_W(H_W), .V_W(V_W), .TA_W(TA_W), .ROW_BITS(ROW_BITS)) bus ();

   char_fetch #(
      .COLS(COLS), .ROW_BITS(ROW_BITS), .V_ACTIVE(V_ACTIVE),
      .H_W(H_W), .V_W(V_W), .TA_W(TA_W)
   ) dut (
      .PIXCLK  (PIXCLK),
      .RESET_N (RESET_N),
      .bus     (bus)
   );

   logic [15:0] ram [4096];
   logic [7:0]  rom [4096];

   // Synchronous memories: data valid one clock after the address.
   always @(posedge PIXCLK) begin
      bus.TEXT_CHAR <= ram[bus.TEXT_ADDR][15:8];
      bus.TEXT_ATTR <= ram[bus.TEXT_ADDR][7:0];
      bus.FONT_DATA <= rom[bus.FONT_ADDR];
   end

   typedef struct {
      logic [9:0]  h;
      logic [9:0]  v;
      logic        act;
      logic [11:0] ta;
      logic [11:0] fa;
      logic [7:0]  data;
      logic [7:0]  attr;
      logic [2:0]  pix;
      logic        blank;
   } vec_t;

   vec_t        sb_q[$];
   vec_t        first_cell[8];
   int          checks   = 0;
   int          failures = 0;
   logic [11:0] m_rb     = 12'd0;
   int          frame    = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (frame %0d)", name, got, exp, frame);
      end
   endtask

   function automatic vec_t model_vec(input logic [9:0] h, input logic [9:0] v, input logic act);
      vec_t        e;
      logic [15:0] w;
      e.h     = h;
      e.v     = v;
      e.act   = act;
      e.ta    = m_rb + {5'd0, h[9:3]};
      w       = ram[e.ta];
      e.fa    = {w[15:8], v[3:0]};
      e.data  = act ? rom[e.fa] : 8'h00;
      e.attr  = act ? w[7:0] : 8'h00;
      e.pix   = h[2:0];
      e.blank = ~act;
      return e;
   endfunction

   task automatic model_update(input logic [9:0] h, input logic [9:0] v);
      if (h == 10'd640) begin
         if (v >= 10'd479) m_rb = 12'd0;
         else if (v[3:0] == 4'hF) m_rb = m_rb + 12'd80;
      end
   endtask

   task automatic check_outputs();
      vec_t e;
      if (sb_q.size() >= 1) chk("text_addr", 32'(bus.TEXT_ADDR), 32'(sb_q[sb_q.size()-1].ta));
      if (sb_q.size() >= 3) chk("font_addr", 32'(bus.FONT_ADDR), 32'(sb_q[sb_q.size()-3].fa));
      if (sb_q.size() >= FETCH_LATENCY) begin
         e = sb_q.pop_front();
         chk("data",  32'(bus.DATA),  32'(e.data));
         chk("attr",  32'(bus.ATTR),  32'(e.attr));
         chk("pixel", 32'(bus.PIXEL), 32'(e.pix));
         chk("blank", 32'(bus.BLANK), 32'(e.blank));
         if (e.v == 10'd5 && e.h == 10'd639 && e.ta == 12'd79)
            chk("col79_attr", 32'(bus.ATTR), 32'(ram[79][7:0]));
         if (e.v == 10'd5 && e.h == 10'd640) begin
            chk("blank_edge_blank", 32'(bus.BLANK), 32'd1);
            chk("blank_edge_attr",  32'(bus.ATTR),  32'd0);
         end
      end else begin
         chk("refill_blank", 32'(bus.BLANK), 32'd1);
         chk("refill_data",  32'(bus.DATA),  32'd0);
         chk("refill_attr",  32'(bus.ATTR),  32'd0);
      end
   endtask

   task automatic drive_cycle(input vec_t e);
      bus.H_COUNT = e.h;
      bus.V_COUNT = e.v;
      bus.ACTIVE  = e.act;
      sb_q.push_back(e);
      @(posedge PIXCLK);
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      RESET_N     = 1'b0;
      bus.H_COUNT = 10'd0;
      bus.V_COUNT = 10'd0;
      bus.ACTIVE  = 1'b1;
      sb_q.delete();
      m_rb = 12'd0;
      for (int i = 0; i < 2; i++) begin
         @(posedge PIXCLK);
         #1;
         chk("rst_blank",     32'(bus.BLANK),     32'd1);
         chk("rst_data",      32'(bus.DATA),      32'd0);
         chk("rst_attr",      32'(bus.ATTR),      32'd0);
         chk("rst_text_addr", 32'(bus.TEXT_ADDR), 32'd0);
         chk("rst_font_addr", 32'(bus.FONT_ADDR), 32'd0);
      end
      RESET_N = 1'b1;
   endtask

   // Compressed line: start of the active area and the horizontal-blank boundary.
   task automatic run_line(input logic [9:0] v);
      vec_t       e;
      logic [9:0] h;
      logic       act;
      for (int j = 0; j < 32; j++) begin
         h   = (j < 16) ? 10'(j) : 10'(616 + j);
         act = (h < 10'd640) && (v < 10'd480);
         e   = model_vec(h, v, act);
         drive_cycle(e);
         model_update(h, v);
         if (h == 10'd0 && v == 10'd0)
            chk("frame_start_addr", 32'(bus.TEXT_ADDR), 32'd0);
         if (frame == 0 && v == 10'd16 && h == 10'd8)
            chk("row_adv_addr", 32'(bus.TEXT_ADDR), 32'd81);
         if (frame == 0 && v == 10'd17 && h == 10'd0)
            chk("row_hold_addr", 32'(bus.TEXT_ADDR), 32'd80);
         if (frame == 0 && v == 10'd479 && h == 10'd0)
            chk("last_row_addr", 32'(bus.TEXT_ADDR), 32'd2320);
         if (frame == 2 && v == 10'd32 && h == 10'd0)
            chk("post_rst_row2_addr", 32'(bus.TEXT_ADDR), 32'd160);
      end
   endtask

   initial begin
      logic [11:0] a;
      for (int i = 0; i < 4096; i++) begin
         a      = 12'(i);
         ram[i] = {a[7:0] ^ 8'h3C, a[3:0] | 4'h8, a[7:4] ^ a[11:8]};
         rom[i] = a[7:0] ^ {a[11:8], a[3:0]} ^ 8'h96;
      end
      ram[0]      = 16'h411F;
      rom[12'h410] = 8'h18;

      for (int i = 0; i < 8; i++) begin
         first_cell[i].h     = 10'(i);
         first_cell[i].v     = 10'd0;
         first_cell[i].act   = 1'b1;
         first_cell[i].ta    = 12'd0;
         first_cell[i].fa    = 12'h410;
         first_cell[i].data  = 8'h18;
         first_cell[i].attr  = 8'h1F;
         first_cell[i].pix   = 3'(i);
         first_cell[i].blank = 1'b0;
      end

      do_reset();

      for (int i = 0; i < 8; i++) begin
         drive_cycle(first_cell[i]);
         model_update(first_cell[i].h, first_cell[i].v);
         if (i == 0) chk("post_rst_font_addr", 32'(bus.FONT_ADDR), 32'd0);
      end

      frame = 0;
      for (int v = 0; v < 525; v++) run_line(10'(v));

      frame = 1;
      for (int v = 0; v < 200; v++) run_line(10'(v));
      do_reset();
      for (int v = 200; v < 525; v++) run_line(10'(v));

      frame = 2;
      for (int v = 0; v < 34; v++) run_line(10'(v));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
